// File: rtl/keyinput_deb_if.sv
// keyinput_deb_if: button front-end bundle (raw lines in, debounced level and pulses out)
//   btn           raw asynchronous button lines
//   level         debounced pressed state, 1 = pressed
//   press         one-cycle pulse per accepted press (and per auto-repeat)
//   release_pulse one-cycle pulse per accepted release
//   any_level     OR of level
//   master: board/test side, slave: keyinput_deb
interface keyinput_deb_if #(parameter int N_KEYS = 7);
  logic [N_KEYS-1:0] btn;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] release_pulse;
  logic              any_level;
  modport master(output btn, input level, press, release_pulse, any_level);
  modport slave(input btn, output level, press, release_pulse, any_level);
endinterface

// File: rtl/keyinput_deb.sv
// keyinput_deb: multi-channel push-button synchroniser, tick-based debouncer and press/release pulse generator
//   clk   system clock
//   rst_n asynchronous active-low reset
//   kb    keyinput_deb_if.slave: btn in; level, press, release_pulse, any_level out
// Optional auto-repeat of press pulses while a key is held: define KEYINPUT_AUTOREPEAT_EN.
module keyinput_deb #(
  parameter int N_KEYS          = 7,
  parameter int TICK_DIV        = 50000,
  parameter int DEB_SAMPLES     = 4,
  parameter int BTN_ACTIVE_HIGH = 1,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input logic          clk,
  input logic          rst_n,
  keyinput_deb_if.slave kb
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_SAMPLES + 1);
  localparam logic [N_KEYS-1:0] INV = (BTN_ACTIVE_HIGH != 0) ? '0 : '1;
  if (TICK_DIV < 2 || DEB_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keyinput_deb: illegal parameter set");
  end
  logic [TW-1:0]     div_q, div_d;
  logic              tick;
  logic [N_KEYS-1:0] meta_q, sync_q;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] rel_q, rel_d;
  assign tick  = div_q == TW'(TICK_DIV - 1);
  assign div_d = tick ? '0 : div_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      meta_q  <= '0;
      sync_q  <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      div_q   <= div_d;
      meta_q  <= kb.btn ^ INV;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end
`ifdef KEYINPUT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
`endif
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [DW-1:0] deb_q, deb_d;
    logic          diff, flip, rep;
    assign diff = sync_q[i] ^ level_q[i];
    // flip: this tick supplies the DEB_SAMPLES-th consecutive differing sample
    assign flip  = tick & diff & (deb_q == DW'(DEB_SAMPLES - 1));
    assign deb_d = !tick ? deb_q : (!diff || flip) ? '0 : deb_q + 1'b1;
    assign level_d[i] = level_q[i] ^ flip;
    assign press_d[i] = (flip & ~level_q[i]) | rep;
    assign rel_d[i]   = flip & level_q[i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) deb_q <= '0;
      else deb_q <= deb_d;
    end
`ifdef KEYINPUT_AUTOREPEAT_EN
    logic [RW-1:0] rep_q, rep_d, rep_n, tgt;
    logic          arm_q, arm_d, idle;
    // arm_q: first repeat already emitted, so the period is REPEAT_RATE rather than REPEAT_DELAY
    assign idle  = flip | ~level_q[i];
    assign tgt   = arm_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
    assign rep_n = rep_q + 1'b1;
    assign rep   = tick & ~idle & (rep_n == tgt);
    assign rep_d = idle ? '0 : !tick ? rep_q : rep ? '0 : rep_n;
    assign arm_d = ~idle & (arm_q | rep);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_q <= '0;
        arm_q <= 1'b0;
      end else begin
        rep_q <= rep_d;
        arm_q <= arm_d;
      end
    end
`else
    assign rep = 1'b0;
`endif
  end
  assign kb.level         = level_q;
  assign kb.press         = press_q;
  assign kb.release_pulse = rel_q;
  assign kb.any_level     = |level_q;
endmodule

// File: tb/tb_keyinput_deb.sv
// tb_keyinput_deb: directed checks of keyinput_deb (N_KEYS=3, TICK_DIV=4, DEB_SAMPLES=3, repeat 8/2)
module tb_keyinput_deb;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pc[3];
  int   rc[3];
  logic out_or;
  logic [2:0] lvl_or;
  int   pt[$];
  int   rt0;
  always #5 clk = ~clk;
  keyinput_deb_if #(.N_KEYS(3)) kb ();
  keyinput_deb #(
    .N_KEYS(3), .TICK_DIV(4), .DEB_SAMPLES(3), .BTN_ACTIVE_HIGH(1),
    .REPEAT_DELAY(8), .REPEAT_RATE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kb(kb)
  );
  task automatic clear();
    for (int k = 0; k < 3; k++) begin
      pc[k] = 0;
      rc[k] = 0;
    end
    out_or = 1'b0;
    lvl_or = '0;
  endtask
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        pc[k] += int'(kb.press[k]);
        rc[k] += int'(kb.release_pulse[k]);
      end
      if (kb.press[0]) pt.push_back(cyc);
      if (kb.release_pulse[0] && rt0 == 0) rt0 = cyc;
      lvl_or |= kb.level;
      out_or |= (|{kb.level, kb.press, kb.release_pulse, kb.any_level});
    end
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  initial begin
    int late;
    rt0 = 0;
    kb.btn = 3'b111;
    rst_n = 1'b0;
    clear();
    run(10);
    chk("rst_outputs_quiet", int'(out_or), 0);
    rst_n = 1'b1;
    clear();
    run(1);
    chk("rst_release_no_pulse", pc[0] + pc[1] + pc[2], 0);
    clear();
    run(14);
    chk("rst_held_press0", pc[0], 1);
    chk("rst_held_press1", pc[1], 1);
    chk("rst_held_press2", pc[2], 1);
    chk("rst_held_level", int'(kb.level), 7);
    chk("rst_held_any", int'(kb.any_level), 1);
    kb.btn = 3'b000;
    clear();
    run(20);
    chk("all_release_pulses", rc[0] + rc[1] + rc[2], 3);
    chk("all_release_level", int'(kb.level), 0);
    chk("all_release_any", int'(kb.any_level), 0);
    // glitch of 6 cycles spans at most 2 ticks
    clear();
    kb.btn = 3'b001;
    run(6);
    kb.btn = 3'b000;
    run(20);
    chk("glitch_press", pc[0], 0);
    chk("glitch_release", rc[0], 0);
    chk("glitch_level", int'(lvl_or[0]), 0);
    // clean press/release on channel 1
    clear();
    kb.btn = 3'b010;
    run(14);
    chk("clean_press_latency", pc[1], 1);
    run(26);
    chk("clean_press_single", pc[1], 1);
    chk("clean_level_high", int'(kb.level), 2);
    chk("clean_other_channels", pc[0] + pc[2], 0);
    kb.btn = 3'b000;
    clear();
    run(14);
    chk("clean_release_latency", rc[1], 1);
    chk("clean_level_low", int'(kb.level[1]), 0);
    run(10);
    chk("clean_release_single", rc[1], 1);
    chk("clean_no_press_on_release", pc[1], 0);
    // bounce on channel 2: 3-cycle segments, high first, ending low
    clear();
    for (int s = 0; s < 10; s++) begin
      kb.btn = (s % 2 == 0) ? 3'b100 : 3'b000;
      run(3);
    end
    chk("bounce_no_press", pc[2], 0);
    chk("bounce_no_level", int'(lvl_or[2]), 0);
    kb.btn = 3'b100;
    clear();
    run(14);
    chk("bounce_settle_press", pc[2], 1);
    kb.btn = 3'b000;
    run(20);
    chk("bounce_settle_release", rc[2], 1);
    // reset in the middle of qualifying channel 0
    kb.btn = 3'b001;
    run(6);
    rst_n = 1'b0;
    clear();
    run(4);
    chk("midrst_quiet", int'(out_or), 0);
    rst_n = 1'b1;
    clear();
    run(11);
    chk("midrst_no_early_press", pc[0], 0);
    run(3);
    chk("midrst_full_qual_press", pc[0], 1);
    chk("midrst_level", int'(kb.level[0]), 1);
    kb.btn = 3'b000;
    run(20);
    chk("midrst_level_cleared", int'(kb.level[0]), 0);
    // hold channel 0 for 80 cycles
    clear();
    pt.delete();
    rt0 = 0;
    kb.btn = 3'b001;
    run(80);
`ifdef KEYINPUT_AUTOREPEAT_EN
    chk("rep_enough_presses", int'(pt.size() >= 3), 1);
    for (int j = 1; j < pt.size(); j++)
      chk($sformatf("rep_interval_%0d", j), pt[j] - pt[j-1], (j == 1) ? 32 : 8);
`else
    chk("norep_single_press", pc[0], 1);
`endif
    kb.btn = 3'b000;
    clear();
    run(30);
    chk("hold_release_pulse", rc[0], 1);
    chk("hold_release_seen", int'(rt0 != 0), 1);
    late = 0;
    foreach (pt[j]) if (pt[j] >= rt0) late++;
    chk("hold_no_press_after_release", late, 0);
    chk("hold_final_level", int'(kb.level), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
